// File: rtl/fpga_cfg_pkg.sv
// Shared types and fabric-derived constants for the configuration loader.
package fpga_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } cfg_state_t;

    localparam int unsigned CFG_WORD_WIDTH = 32;

    // Per-tile configuration widths along the daisy chain.
    localparam int unsigned CLB_TILE_COUNT = 8;
    localparam int unsigned CLB_CFG_BITS   = 104;
    localparam int unsigned SRAM_CFG_BITS  = 96;
    localparam int unsigned MAC_CFG_BITS   = 96;

    localparam int unsigned FABRIC_CHAIN_LEN =
        CLB_TILE_COUNT * CLB_CFG_BITS + SRAM_CFG_BITS + MAC_CFG_BITS;

endpackage

// File: rtl/fpga_cfg_piso.sv
// Two-entry parallel-in serial-out buffer: shift register plus one holding register.
// Exposes a look-ahead of the next SR state so the owner can register its outputs.
module fpga_cfg_piso
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = CFG_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  shift,
    input  logic [WORD_WIDTH-1:0] data,
    output logic                  empty,
    output logic                  hr_full,
    output logic                  next_valid_c,
    output logic                  next_bit_c
);

    localparam int unsigned  CW       = $clog2(WORD_WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORD_WIDTH);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [WORD_WIDTH-1:0] sr, sr_n, hr, hr_n;
    logic [CW-1:0]         sr_cnt, sr_cnt_n;
    logic                  sr_valid, sr_valid_n, hr_valid, hr_valid_n;
    logic                  last_bit, sr_free;

    assign last_bit = sr_valid && (sr_cnt == ONE);
    assign sr_free  = !sr_valid || (shift && last_bit);

    // Next-state of both entries; SR refills from HR first, then from the input.
    always_comb begin
        sr_n       = sr;
        sr_cnt_n   = sr_cnt;
        sr_valid_n = sr_valid;
        hr_n       = hr;
        hr_valid_n = hr_valid;

        if (shift && sr_valid) begin
            sr_n     = sr >> 1;
            sr_cnt_n = sr_cnt - ONE;
        end

        if (sr_free) begin
            if (hr_valid) begin
                sr_n       = hr;
                sr_cnt_n   = FULL_CNT;
                sr_valid_n = 1'b1;
                hr_valid_n = 1'b0;
            end else if (load) begin
                sr_n       = data;
                sr_cnt_n   = FULL_CNT;
                sr_valid_n = 1'b1;
            end else begin
                sr_valid_n = 1'b0;
            end
        end

        if (load && !(sr_free && !hr_valid)) begin
            hr_n       = data;
            hr_valid_n = 1'b1;
        end

        if (clear) begin
            sr_n       = '0;
            sr_cnt_n   = '0;
            sr_valid_n = 1'b0;
            hr_n       = '0;
            hr_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            sr_cnt   <= '0;
            sr_valid <= 1'b0;
            hr       <= '0;
            hr_valid <= 1'b0;
        end else begin
            sr       <= sr_n;
            sr_cnt   <= sr_cnt_n;
            sr_valid <= sr_valid_n;
            hr       <= hr_n;
            hr_valid <= hr_valid_n;
        end
    end

    assign empty        = !sr_valid;
    assign hr_full      = hr_valid;
    assign next_valid_c = sr_valid_n;
    assign next_bit_c   = sr_n[0];

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration bitstream transmitter: streams words LSB first onto the fabric
// scan chain and stops after exactly CHAIN_LEN shifted bits.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = CFG_WORD_WIDTH,
    parameter int unsigned CHAIN_LEN  = FABRIC_CHAIN_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  cfg_en,
    output logic                  cfg_bit,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned      CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    cfg_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             sr_empty, hr_full, next_valid, next_bit;
    logic             accept, shift, begin_load, finish, clear, load_next;

    assign in_ready   = ((state == LOAD) && !hr_full) || (state == DONE);
    assign accept     = in_valid && in_ready;
    assign shift      = (state == LOAD) && !sr_empty;
    assign begin_load = start && (state != LOAD);
    assign finish     = shift && (bit_cnt == LAST_IDX);
    assign clear      = begin_load || finish;
    assign load_next  = ((state == LOAD) && !finish) || begin_load;

    fpga_cfg_piso #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_piso (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (accept && (state == LOAD)),
        .shift        (shift),
        .data         (in_data),
        .empty        (sr_empty),
        .hr_full      (hr_full),
        .next_valid_c (next_valid),
        .next_bit_c   (next_bit)
    );

    // Control FSM, bit counter and registered outputs. cfg_en/cfg_bit present
    // the bit the SR will hold after this edge, so the chain sees it next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            cfg_en   <= 1'b0;
            cfg_bit  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        bit_cnt  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (shift) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    if (finish) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        bit_cnt  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end else if (accept) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            cfg_en  <= load_next && next_valid;
            cfg_bit <= load_next && next_valid && next_bit;
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed self-checking bench for fpga_cfg_loader with a 16-bit word, 40-bit chain.
module tb_fpga_cfg_loader;

    localparam int unsigned WW = 16;
    localparam int unsigned CL = 40;
    localparam logic [39:0] EXP_BITS = 40'hFF_0F0F_A5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_data = '0;
    logic          cfg_en, cfg_bit, busy, done, overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic          log_bit [0:511];
    int            log_cyc [0:511];
    int            n_en     = 0;
    int            cyc_ctr  = 0;
    int            rise_cyc = -1;
    logic          done_q   = 1'b0;
    int            base     = 0;
    logic [WW-1:0] words [0:2];

    fpga_cfg_loader #(
        .WORD_WIDTH (WW),
        .CHAIN_LEN  (CL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .cfg_en   (cfg_en),
        .cfg_bit  (cfg_bit),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Record every bit handed to the chain and when done rises.
    always @(negedge clk) begin
        if (cfg_en && n_en < 512) begin
            log_bit[n_en] = cfg_bit;
            log_cyc[n_en] = cyc_ctr;
            n_en = n_en + 1;
        end
        if (done && !done_q) rise_cyc = cyc_ctr;
        done_q  = done;
        cyc_ctr = cyc_ctr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Start a load and feed the three words; optional hold after word 1,
    // optional start pulse at a given bit count, optional abort at a bit count.
    task automatic feed(input int hold_after_first, input int start_bit, input int abort_bit);
        int k    = 0;
        int hold = 0;
        int cyc  = 0;
        logic acc;
        pulse_start();
        base = n_en;
        while (!done && cyc < 300 && !(abort_bit >= 0 && (n_en - base) == abort_bit)) begin
            in_valid = (k < 3) && (hold == 0);
            in_data  = (k < 3) ? words[k] : '0;
            start    = (start_bit >= 0) && ((n_en - base) == start_bit);
            acc      = in_valid && in_ready;
            step();
            cyc = cyc + 1;
            if (hold > 0) hold = hold - 1;
            if (acc) begin
                if (k == 0) hold = hold_after_first;
                k = k + 1;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = '0;
        if (abort_bit >= 0) chk("abort_reached", 64'(n_en - base), 64'(abort_bit));
        else                chk("load_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic check_load(input string tag, input int exp_span);
        logic [39:0] got;
        repeat (3) step();
        for (int i = 0; i < 40; i++) got[i] = log_bit[base + i];
        chk({tag, "_count"}, 64'(n_en - base), 64'(CL));
        chk({tag, "_bits"}, {24'd0, got}, {24'd0, EXP_BITS});
        chk({tag, "_span"}, 64'(log_cyc[base + 39] - log_cyc[base]), 64'(exp_span));
        chk({tag, "_done_rise"}, 64'(rise_cyc), 64'(log_cyc[base + 39] + 1));
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_cfg_en"},   {63'd0, cfg_en},   64'd0);
        chk({tag, "_cfg_bit"},  {63'd0, cfg_bit},  64'd0);
        chk({tag, "_busy"},     {63'd0, busy},     64'd0);
        chk({tag, "_done"},     {63'd0, done},     64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    endtask

    initial begin
        int snap;
        words[0] = 16'hA5A5;
        words[1] = 16'h0F0F;
        words[2] = 16'h00FF;

        // Reset values, during and after reset.
        #1;
        check_all_zero("rst_held");
        step();
        step();
        rst = 1'b0;
        check_all_zero("rst_released");

        // Idle with data offered but no start.
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
            chk("idle_cfg_en",   {63'd0, cfg_en},   64'd0);
            chk("idle_done",     {63'd0, done},     64'd0);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;

        // Gapless load: 40 consecutive shift cycles.
        feed(0, -1, -1);
        check_load("gapless", 39);

        // Word 2 arrives 5 cycles after SR drains: 5-cycle gap.
        feed(WW + 4, -1, -1);
        check_load("gap5", 44);

        // Word after done is swallowed and flags overflow.
        snap = n_en;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        chk("ovf_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_data  = '0;
        chk("ovf_flag",   {63'd0, overflow}, 64'd1);
        chk("ovf_cfg_en", {63'd0, cfg_en},   64'd0);
        step();
        chk("ovf_no_shift", 64'(n_en - snap), 64'd0);
        chk("ovf_sticky",   {63'd0, overflow}, 64'd1);
        pulse_start();
        chk("restart_overflow", {63'd0, overflow}, 64'd0);
        chk("restart_done",     {63'd0, done},     64'd0);
        chk("restart_busy",     {63'd0, busy},     64'd1);

        // Asynchronous reset after 20 bits, then a full reload.
        feed(0, -1, 20);
        rst = 1'b1;
        #1;
        check_all_zero("midload_rst");
        step();
        rst = 1'b0;
        feed(0, -1, -1);
        check_load("after_rst", 39);

        // start during LOAD is ignored.
        feed(0, 10, -1);
        check_load("start_in_load", 39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
